// File: rtl/shift_sequencer.sv
// Multi-cycle left shifter: {spill,dout} moves left by 2 or 1 positions per clock
// until the captured shift count is exhausted, then pulses done for one cycle.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
    input  logic             fill,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] spill,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [AMT_W-1:0] STEP2 = AMT_W'(2);
    localparam logic [AMT_W-1:0] STEP1 = AMT_W'(1);

    logic [1:0]         state;
    logic [AMT_W-1:0]   cnt;
    logic [AMT_W-1:0]   cnt_nxt;
    logic               fill_q;
    logic [2*WIDTH-1:0] r_nxt;

    // Step size is chosen from cnt before the decrement, so cnt never wraps.
    always_comb begin
        r_nxt   = {spill, dout};
        cnt_nxt = cnt;
        if (cnt >= STEP2) begin
            r_nxt   = {spill[WIDTH-3:0], dout, fill_q, fill_q};
            cnt_nxt = cnt - STEP2;
        end else if (cnt == STEP1) begin
            r_nxt   = {spill[WIDTH-2:0], dout, fill_q};
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            fill_q <= 1'b0;
            dout   <= '0;
            spill  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dout   <= din;
                        spill  <= '0;
                        cnt    <= amt;
                        fill_q <= fill;
                        busy   <= 1'b1;
                        state  <= (amt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        {spill, dout} <= r_nxt;
                        cnt           <= cnt_nxt;
                        if (cnt_nxt == '0)
                            state <= DONE;
                    end
                end
                DONE: begin
                    // Pulse lands as the FSM returns to IDLE, so a new start may follow at once.
                    done  <= ~abort;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
